// File: rtl/conv_engine_mc.sv
// Multi-channel layer MAC engine: NUM_CH parallel int8 dot products with bias,
// Q-format requantisation, optional LeakyReLU and int8 saturation per output pixel.
module conv_engine_mc #(
  parameter int NUM_CH   = 4,
  parameter int MACS_MAX = 288,
  parameter int IDX_W    = 9,
  parameter int ACC_W    = 32,
  parameter int SCALE_Q  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IDX_W-1:0]      mac_count,
  input  logic [15:0]           scale,
  input  logic                  leaky_en,
  input  logic [NUM_CH*32-1:0]  bias,
  input  logic [7:0]            act_in,
  input  logic [NUM_CH*8-1:0]   w_in,
  output logic [IDX_W-1:0]      mac_index,
  output logic                  busy,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [NUM_CH*8-1:0]   result,
  output logic                  done
);

  localparam int PW = ACC_W + 17;
  localparam logic [IDX_W-1:0]     MACS_LIM = IDX_W'(MACS_MAX);
  localparam logic signed [PW-1:0] ROUND    = PW'(1) << (SCALE_Q - 1);
  localparam logic signed [PW-1:0] SAT_HI   = PW'(127);
  localparam logic signed [PW-1:0] SAT_LO   = -PW'(128);

  typedef enum logic [1:0] {IDLE, MAC, REQ, OUT} state_t;

  state_t                   state, state_nxt;
  logic [IDX_W-1:0]         n_taps;
  logic [15:0]              scale_q;
  logic                     leaky_q;
  logic signed [ACC_W-1:0]  acc      [NUM_CH];
  logic signed [15:0]       mac_prod [NUM_CH];
  logic signed [PW-1:0]     prod     [NUM_CH];
  logic signed [PW-1:0]     rnd      [NUM_CH];
  logic [NUM_CH*8-1:0]      result_nxt;
  logic [IDX_W-1:0]         n_clamped;
  logic                     last_tap;

  assign n_clamped = (mac_count > MACS_LIM) ? MACS_LIM : mac_count;
  assign last_tap  = (mac_index == n_taps - IDX_W'(1));
  assign busy      = (state != IDLE);

  // NOTE: the state register uses non-blocking assignment so every flop
  // samples pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: state_nxt gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = (n_clamped != '0) ? MAC : REQ;
      MAC:  if (last_tap) state_nxt = REQ;
      REQ:  state_nxt = OUT;
      OUT:  if (result_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Per-channel tap product and requantisation of the finished accumulator.
  always_comb begin
    result_nxt = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      mac_prod[c] = $signed(act_in) * $signed(w_in[c*8 +: 8]);
      prod[c]     = PW'(acc[c]) * PW'($signed({1'b0, scale_q}));
      rnd[c]      = (prod[c] + ROUND) >>> SCALE_Q;
      if (leaky_q && rnd[c][PW-1]) rnd[c] = rnd[c] >>> 3;
      if (rnd[c] > SAT_HI)      result_nxt[c*8 +: 8] = 8'h7F;
      else if (rnd[c] < SAT_LO) result_nxt[c*8 +: 8] = 8'h80;
      else                      result_nxt[c*8 +: 8] = rnd[c][7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mac_index    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      done         <= 1'b0;
      n_taps       <= '0;
      scale_q      <= '0;
      leaky_q      <= 1'b0;
      // NOTE: the accumulators are a handful of flops, not a RAM, so they can
      // and do take the asynchronous reset like every other register.
      for (int c = 0; c < NUM_CH; c++) acc[c] <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: if (start) begin
          n_taps    <= n_clamped;
          scale_q   <= scale;
          leaky_q   <= leaky_en;
          mac_index <= '0;
          for (int c = 0; c < NUM_CH; c++) acc[c] <= ACC_W'($signed(bias[c*32 +: 32]));
        end
        MAC: begin
          // Accumulation wraps in two's complement by design.
          for (int c = 0; c < NUM_CH; c++) acc[c] <= acc[c] + ACC_W'(mac_prod[c]);
          mac_index <= last_tap ? '0 : mac_index + IDX_W'(1);
        end
        REQ: begin
          result       <= result_nxt;
          result_valid <= 1'b1;
          done         <= 1'b1;
        end
        OUT: if (result_ready) result_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_engine_mc.sv
// Directed self-checking bench for conv_engine_mc: golden patch, four-channel
// requant/leaky/saturation, tap-count boundaries, backpressure and mid-run reset.
module tb_conv_engine_mc;

  localparam int NUM_CH = 4;
  localparam int IDX_W  = 9;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 start;
  logic [IDX_W-1:0]     mac_count;
  logic [15:0]          scale;
  logic                 leaky_en;
  logic [NUM_CH*32-1:0] bias;
  logic [7:0]           act_in;
  logic [NUM_CH*8-1:0]  w_in;
  logic [IDX_W-1:0]     mac_index;
  logic                 busy;
  logic                 result_valid;
  logic                 result_ready;
  logic [NUM_CH*8-1:0]  result;
  logic                 done;

  logic [7:0]           act_mem [512];
  logic [NUM_CH*8-1:0]  w_mem   [512];

  int n_cmp = 0;
  int n_err = 0;
  int done_cnt = 0;

  conv_engine_mc dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mac_count(mac_count), .scale(scale),
    .leaky_en(leaky_en), .bias(bias), .act_in(act_in), .w_in(w_in),
    .mac_index(mac_index), .busy(busy), .result_valid(result_valid),
    .result_ready(result_ready), .result(result), .done(done)
  );

  always #5 clk = ~clk;

  assign act_in = act_mem[mac_index];
  assign w_in   = w_mem[mac_index];

  always @(posedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic fill(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 512; i++) begin
      act_mem[i] = a;
      w_mem[i]   = w;
    end
  endtask

  // act[i] = w0[i] = i-13 over 27 taps: sum of squares 1638.
  task automatic fill_golden();
    for (int i = 0; i < 512; i++) begin
      act_mem[i] = 8'(i - 13);
      w_mem[i]   = {24'd0, 8'(i - 13)};
    end
  endtask

  // Start a pixel, scramble the latched inputs, and wait (bounded) for result_valid.
  task automatic run(input logic [IDX_W-1:0] cnt, input logic [15:0] sc, input logic lk,
                     input logic [127:0] b, output int edges, output logic [31:0] res,
                     output logic dn);
    @(negedge clk);
    mac_count = cnt; scale = sc; leaky_en = lk; bias = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0; mac_count = '1; scale = 16'h0; leaky_en = ~lk; bias = '1;
    edges = 0;
    while (!result_valid && edges < 1000) begin
      @(negedge clk);
      edges++;
    end
    res = result;
    dn  = done;
  endtask

  task automatic accept();
    @(negedge clk);
    result_ready = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    check("accept_valid", 64'(result_valid), 64'd0);
    check("accept_busy", 64'(busy), 64'd0);
  endtask

  localparam logic [127:0] BIAS_GOLD = {96'd0, 32'd1000};
  localparam logic [127:0] BIAS_4CH  = {32'hFFFF_FC18, 32'd500, 32'd0, 32'd0};
  localparam logic [31:0]  W_4CH     = {8'h00, 8'h02, 8'hFF, 8'h01};

  initial begin
    int          edges;
    logic [31:0] res;
    logic        dn;
    logic [31:0] held;
    int          done_base;

    rst_n = 1'b0; start = 1'b0; mac_count = '0; scale = '0; leaky_en = 1'b0;
    bias = '0; result_ready = 1'b0;
    fill(8'd0, 32'd0);

    // Reset state
    @(negedge clk);
    check("rst_mac_index", 64'(mac_index), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    rst_n = 1'b1;

    // Golden single channel: (1638+1000)*655 -> 26
    fill_golden();
    run(9'd27, 16'd655, 1'b0, BIAS_GOLD, edges, res, dn);
    check("gold_latency", 64'(edges), 64'd28);
    check("gold_done", 64'(dn), 64'd1);
    check("gold_result", 64'(res), 64'h0000_001A);
    accept();

    // Four channels, no leaky: {14,-13,127,-128}
    fill(8'd1, W_4CH);
    run(9'd27, 16'd32768, 1'b0, BIAS_4CH, edges, res, dn);
    check("4ch_latency", 64'(edges), 64'd28);
    check("4ch_result", 64'(res), 64'h807F_F30E);
    accept();

    // Four channels with LeakyReLU: {14,-2,127,-63}
    run(9'd27, 16'd32768, 1'b1, BIAS_4CH, edges, res, dn);
    check("leaky_result", 64'(res), 64'hC17F_FE0E);
    accept();

    // Zero taps: bias only, 100*0.5 = 50
    run(9'd0, 16'd32768, 1'b0, {96'd0, 32'd100}, edges, res, dn);
    check("n0_latency", 64'(edges), 64'd1);
    check("n0_result", 64'(res), 64'h0000_0032);
    check("n0_mac_index", 64'(mac_index), 64'd0);
    accept();

    // mac_count=300 clamps to 288: bias -288 cancels exactly 288 unit taps
    fill(8'd1, 32'h0000_0001);
    run(9'd300, 16'd32768, 1'b0, {96'd0, 32'hFFFF_FEE0}, edges, res, dn);
    check("clamp_latency", 64'(edges), 64'd289);
    check("clamp_result", 64'(res), 64'h0000_0000);
    accept();

    // Backpressure: hold off acceptance, poke start, then start on accept edge
    fill_golden();
    done_base = done_cnt;
    run(9'd27, 16'd655, 1'b0, BIAS_GOLD, edges, res, dn);
    held = res;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      start = (k == 2);
      check("bp_result", 64'(result), 64'(held));
      check("bp_valid", 64'(result_valid), 64'd1);
      check("bp_busy", 64'(busy), 64'd1);
      check("bp_mac_index", 64'(mac_index), 64'd0);
    end
    start = 1'b0;
    @(negedge clk);
    check("bp_done_count", 64'(done_cnt - done_base), 64'd1);
    result_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    result_ready = 1'b0;
    start = 1'b0;
    check("accept_start_ignored", 64'(busy), 64'd0);
    @(negedge clk);
    check("still_idle", 64'(busy), 64'd0);
    fill(8'd1, W_4CH);
    run(9'd27, 16'd32768, 1'b0, BIAS_4CH, edges, res, dn);
    check("bp_next_result", 64'(res), 64'h807F_F30E);
    accept();

    // Asynchronous reset in the middle of a golden run
    fill_golden();
    @(negedge clk);
    mac_count = 9'd27; scale = 16'd655; leaky_en = 1'b0; bias = BIAS_GOLD; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    edges = 0;
    while (mac_index != 9'd10 && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("mid_reach_10", 64'(mac_index), 64'd10);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_mac_index", 64'(mac_index), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_result", 64'(result), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    check("mid_rst_valid", 64'(result_valid), 64'd0);
    rst_n = 1'b1;
    run(9'd27, 16'd655, 1'b0, BIAS_GOLD, edges, res, dn);
    check("post_rst_latency", 64'(edges), 64'd28);
    check("post_rst_result", 64'(res), 64'h0000_001A);
    accept();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/conv_engine_mc.md
Name: conv_engine_mc

Overview:
Multi-channel successor to the single-channel layer-0 MAC engine. Computes NUM_CH output channels in parallel for one output pixel: a runtime-length dot product of a shared int8 activation stream against per-channel int8 weights, plus a 32-bit bias, then Q-format requantisation, optional LeakyReLU and int8 saturation. Drives a shared mac_index into the activation/weight buffers and returns results over a valid/ready handshake to the output writer.

Parameters:
NUM_CH, 4, output channels computed in parallel
MACS_MAX, 288, maximum taps per dot product (3x3x32)
IDX_W, 9, width of mac_index and mac_count (must hold MACS_MAX)
ACC_W, 32, accumulator width per channel
SCALE_Q, 16, fractional bits of scale

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  begin a pixel; sampled only in IDLE
mac_count  in  IDX_W  taps for this pixel; latched at start
scale  in  16  unsigned requant multiplier (Q0.SCALE_Q); latched at start
leaky_en  in  1  enable LeakyReLU; latched at start
bias  in  NUM_CH*32  signed per-channel bias (ch0 at LSBs); latched at start
act_in  in  8  signed activation at mac_index (combinational buffer read)
w_in  in  NUM_CH*8  signed weights at mac_index, ch0 at LSBs
mac_index  out  IDX_W  current tap address
busy  out  1  high in any state except IDLE
result_valid  out  1  result vector valid
result_ready  in  1  downstream accepts result
result  out  NUM_CH*8  signed int8 results, ch0 at LSBs
done  out  1  one-cycle pulse when result_valid first rises

Behaviour:
- Reset (async, any state): state IDLE; mac_index, result, result_valid, done, busy and accumulators all 0.
- FSM: IDLE -> MAC -> REQ -> OUT -> IDLE.
- IDLE: on a clock edge with start=1, latch the clamped count N=min(mac_count,MACS_MAX), scale and leaky_en; set acc[c]=bias[c] and mac_index=0. Go to MAC if N>0, otherwise to REQ.
- MAC: on each edge, acc[c] += act_in*w_in[c]. The 16-bit signed product is sign-extended. If mac_index==N-1, go to REQ and set mac_index=0; otherwise mac_index+1. This takes exactly N cycles. The accumulator wraps in two's complement and does not saturate.
- REQ, one cycle, per channel:
  - p = acc * {0,scale} (signed, ACC_W+17 bits).
  - s = (p + 2^(SCALE_Q-1)) >>> SCALE_Q (round half up).
  - If leaky_en and s<0, then s = s >>> 3 (slope 1/8, floor).
  - Saturate to [-128,127], register into result, set result_valid=1 and done=1 for that cycle only. Go to OUT.
- Latency: result_valid is high N+1 edges after the start edge (1 edge when N=0).
- OUT: result and result_valid stay stable until an edge with result_ready=1. On that edge, clear result_valid and go to IDLE. result_ready is ignored outside OUT.
- start while busy is ignored (not queued). A start on the same edge as result acceptance is also ignored; a new start is only taken from IDLE.
- mac_index is 0 in IDLE, REQ and OUT.
- Inputs other than act_in/w_in may change after the start edge without effect.

Test Plan:
- Golden one-channel check: mac_count=27, scale=655, ch0 weights/acts/bias from layer0_patch_*.hex. Required: result[7:0] == layer0_patch_expected, and done occurs 28 edges after start.
- Four channels, 27 taps, act=1 for all taps, w={1,-1,2,0}, bias={0,0,500,-1000}, scale=32768, leaky_en=0. Required: result={14,-13,127,-128}.
- Same stimulus as the previous scenario but leaky_en=1. Required: result={14,-2,127,-63}.
- mac_count=0, bias ch0=100, scale=32768. Required: result_valid 1 edge after start, result ch0=50, mac_index stays 0. Also mac_count=300 must run exactly 288 MAC cycles.
- Backpressure: hold result_ready=0 for 5 cycles in OUT and pulse start. Required: result stable, busy=1, no restart, done high for only one cycle. Then result_ready=1 returns the block to IDLE, and the next start works.
- Assert rst_n=0 at mac_index=10 during a 27-tap run. Required: all outputs 0 immediately with no result_valid. After release, a fresh run gives the correct golden result.
